// File: rtl/common_pkg.sv
// Shared cbus transaction types and arbiter state encoding used across the
// memory-side blocks.
package common;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mmu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after last_grant,
// scanning upward and wrapping. Reusable for any N-way arbiter.
module rr_pick #(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] winner,
    output logic          any
);

    logic [GW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(last_grant) + k) % N);
            if (!any && valid[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_arbiter.sv
// Round-robin owner of the single MMU cbus port: grants one requester per
// transaction, holds it until ready&&last, then idles one release cycle.
module mmu_arbiter
    import common::*;
#(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  cbus_req_t     req_in [N],
    output cbus_resp_t    resp_out [N],
    output cbus_req_t     req_out,
    input  cbus_resp_t    resp_in,
    output logic          grant_valid,
    output logic [GW-1:0] grant_id
);

    arb_state_t    state;
    logic [GW-1:0] last_grant;
    logic [N-1:0]  req_valid;
    logic [GW-1:0] pick_winner;
    logic          pick_any;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N; i++) req_valid[i] = req_in[i].valid;
    end

    rr_pick #(.N(N), .GW(GW)) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // Owner's request goes straight through; everyone else sees an all-zero response.
    always_comb begin
        req_out = '0;
        for (int j = 0; j < N; j++) begin
            resp_out[j] = '0;
            if (state == BUSY && grant_id == GW'(j)) begin
                req_out     = req_in[j];
                resp_out[j] = resp_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking throughout so each register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GW'(N - 1);
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant_id    <= pick_winner;
                    grant_valid <= 1'b1;
                    state       <= BUSY;
                end
                BUSY: if (resp_in.ready && resp_in.last) begin
                    last_grant  <= grant_id;
                    grant_valid <= 1'b0;
                    grant_id    <= '0;
                    state       <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The MMU re-reads the owner's request during a walk, so it must stay valid.
    owner_holds_valid: assert property (
        @(posedge clk) disable iff (rst) (state == BUSY) |-> req_valid[grant_id]
    );

endmodule

// File: tb/tb_mmu_arbiter.sv
// Self-checking bench for mmu_arbiter (N=3): directed scenarios plus random
// traffic, compared every cycle against a behavioural ownership model.
module tb_mmu_arbiter;
    import common::*;

    localparam int N  = 3;
    localparam int GW = $clog2(N);

    logic          clk;
    logic          rst;
    cbus_req_t     req_in [N];
    cbus_resp_t    resp_out [N];
    cbus_req_t     req_out;
    cbus_resp_t    resp_in;
    logic          grant_valid;
    logic [GW-1:0] grant_id;

    mmu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .resp_out    (resp_out),
        .req_out     (req_out),
        .resp_in     (resp_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // stimulus controls
    int          prob [N];
    bit          done_flag [N];
    bit          mmu_rand;
    int          mmu_lat;
    int          mmu_beats;
    logic [31:0] mmu_data;
    bit          mmu_seen_valid;

    // observation
    int grant_q[$];
    int grant_cyc_q[$];
    int done_cyc_q[$];
    int beats_seen [N];
    bit gv_prev;

    // reference model: current owner (-1 none), release pending, last owner
    int m_owner;
    bit m_cool;
    int m_last;
    int wait_cnt [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_ref(input int last);
        for (int k = 1; k <= N; k++) begin
            if (req_in[(last + k) % N].valid) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int grant_at(input int i);
        return (i < grant_q.size()) ? grant_q[i] : -1;
    endfunction

    // Behavioural model: who must own the port after each edge.
    initial begin
        m_owner = -1;
        m_cool  = 1'b0;
        m_last  = N - 1;
        foreach (wait_cnt[j]) wait_cnt[j] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = -1;
                m_cool  = 1'b0;
                m_last  = N - 1;
                foreach (wait_cnt[j]) wait_cnt[j] = 0;
            end else if (m_owner >= 0) begin
                if (resp_in.ready && resp_in.last) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_cool  = 1'b1;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (rr_ref(m_last) >= 0) begin
                m_owner = rr_ref(m_last);
                check("starvation_bound", 128'(wait_cnt[m_owner] <= N - 1), 128'(1));
                for (int j = 0; j < N; j++) begin
                    if (j == m_owner) wait_cnt[j] = 0;
                    else if (req_in[j].valid) wait_cnt[j]++;
                end
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        cbus_req_t  exp_req;
        cbus_resp_t exp_resp;
        @(negedge clk);
        if (!rst) begin
            exp_req = (m_owner >= 0) ? req_in[m_owner] : '0;
            check("grant_valid", 128'(grant_valid), 128'(m_owner >= 0));
            check("grant_id", 128'(grant_id), 128'((m_owner >= 0) ? m_owner : 0));
            check("req_out", 128'(req_out), 128'(exp_req));
            for (int j = 0; j < N; j++) begin
                exp_resp = (j == m_owner) ? resp_in : '0;
                check($sformatf("resp_out%0d", j), 128'(resp_out[j]), 128'(exp_resp));
            end
        end
    end

    // Monitor for directed checks and stimulus feedback.
    initial begin
        gv_prev = 1'b0;
        forever begin
            @(negedge clk);
            mmu_seen_valid = req_out.valid;
            if (!rst) begin
                for (int j = 0; j < N; j++) begin
                    if (resp_out[j].ready) beats_seen[j]++;
                    if (resp_out[j].ready && resp_out[j].last) done_flag[j] = 1'b1;
                end
                if (grant_valid && !gv_prev) begin
                    grant_q.push_back(int'(grant_id));
                    grant_cyc_q.push_back(cyc);
                end
                if (grant_valid && resp_in.ready && resp_in.last) done_cyc_q.push_back(cyc);
            end
            gv_prev = grant_valid;
        end
    end

    // Requesters: raise with probability prob[j], hold until own ready&&last.
    initial forever begin
        step();
        for (int j = 0; j < N; j++) begin
            if (done_flag[j]) begin
                req_in[j].valid = 1'b0;
                done_flag[j]    = 1'b0;
            end else if (!req_in[j].valid && int'($urandom_range(99, 0)) < prob[j]) begin
                req_in[j] = '{valid: 1'b1, write: 1'($urandom), addr: $urandom, wdata: $urandom};
            end
        end
    end

    // MMU model: answers each accepted request after mmu_lat cycles with mmu_beats beats.
    initial begin
        int phase;
        int cnt;
        int beat;
        int lat;
        int beats;
        phase   = 0;
        cnt     = 0;
        beat    = 0;
        lat     = 1;
        beats   = 1;
        resp_in = '0;
        forever begin
            step();
            resp_in = '0;
            if (rst) begin
                phase = 0;
            end else if (phase == 2) begin
                phase = 0;
            end else begin
                if (phase == 0 && mmu_seen_valid) begin
                    lat   = mmu_rand ? int'($urandom_range(6, 1)) : mmu_lat;
                    beats = mmu_rand ? int'($urandom_range(4, 1)) : mmu_beats;
                    cnt   = lat - 1;
                    beat  = 0;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        resp_in.ready = 1'b1;
                        resp_in.last  = (beat == beats - 1);
                        resp_in.data  = mmu_rand ? $urandom : mmu_data;
                        beat++;
                        if (resp_in.last) phase = 2;
                        else cnt = mmu_rand ? int'($urandom_range(2, 0)) : 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        for (int j = 0; j < N; j++) begin
            req_in[j]     = '0;
            done_flag[j]  = 1'b0;
            beats_seen[j] = 0;
        end
        step();
        step();
        rst = 1'b0;
        grant_q.delete();
        grant_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic wait_grants(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && grant_q.size() < n; i++) @(negedge clk);
        check({tag, "_grant_count"}, 128'(grant_q.size() >= n), 128'(1));
    endtask

    initial begin
        int lat_seen;
        bit found;
        rst       = 1'b1;
        mmu_rand  = 1'b0;
        mmu_lat   = 5;
        mmu_beats = 1;
        mmu_data  = 32'h1234;
        foreach (prob[j]) prob[j] = 0;
        foreach (req_in[j]) req_in[j] = '0;

        // reset values while rst is held
        step();
        check("rst_grant_valid", 128'(grant_valid), 128'(0));
        check("rst_grant_id", 128'(grant_id), 128'(0));
        check("rst_req_out", 128'(req_out), 128'(0));
        for (int j = 0; j < N; j++) check($sformatf("rst_resp_out%0d", j), 128'(resp_out[j]), 128'(0));

        // single requester, 5-cycle MMU answer
        do_reset();
        step();
        req_in[0] = '{valid: 1'b1, write: 1'b0, addr: 32'h8000_0000, wdata: 32'h0};
        @(negedge clk);
        check("t1_req_valid_at_t", 128'(req_out.valid), 128'(0));
        @(negedge clk);
        check("t1_req_valid_at_t1", 128'(req_out.valid), 128'(1));
        check("t1_req_addr", 128'(req_out.addr), 128'(32'h8000_0000));
        lat_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_out[0].ready) begin
                lat_seen = k;
                break;
            end
        end
        check("t1_latency", 128'(lat_seen), 128'(5));
        check("t1_resp0_data", 128'(resp_out[0].data), 128'(32'h1234));
        check("t1_resp0_last", 128'(resp_out[0].last), 128'(1));
        check("t1_resp1_zero", 128'(resp_out[1]), 128'(0));
        @(negedge clk);
        check("t1_release_req_valid", 128'(req_out.valid), 128'(0));
        check("t1_release_grant_valid", 128'(grant_valid), 128'(0));

        // two ports continuously requesting
        do_reset();
        mmu_lat = 2;
        prob[0] = 100;
        prob[1] = 100;
        wait_grants("t2", 4, 200);
        check("t2_order0", 128'(grant_at(0)), 128'(0));
        check("t2_order1", 128'(grant_at(1)), 128'(1));
        check("t2_order2", 128'(grant_at(2)), 128'(0));
        check("t2_order3", 128'(grant_at(3)), 128'(1));
        foreach (prob[j]) prob[j] = 0;

        // three ports continuously requesting
        do_reset();
        foreach (prob[j]) prob[j] = 100;
        wait_grants("t3", 4, 200);
        check("t3_order0", 128'(grant_at(0)), 128'(0));
        check("t3_order1", 128'(grant_at(1)), 128'(1));
        check("t3_order2", 128'(grant_at(2)), 128'(2));
        check("t3_order3", 128'(grant_at(3)), 128'(0));
        foreach (prob[j]) prob[j] = 0;

        // four-beat burst to port 0 while port 1 waits
        do_reset();
        mmu_beats = 4;
        prob[0]   = 100;
        prob[1]   = 100;
        wait_grants("t4", 2, 200);
        check("t4_beats_port0", 128'(beats_seen[0]), 128'(4));
        check("t4_beats_port1", 128'(beats_seen[1]), 128'(0));
        check("t4_beats_port2", 128'(beats_seen[2]), 128'(0));
        check("t4_order1", 128'(grant_at(1)), 128'(1));
        check("t4_regrant_gap", 128'((grant_cyc_q.size() > 1 && done_cyc_q.size() > 0) ?
              grant_cyc_q[1] - done_cyc_q[0] : -1), 128'(3));
        foreach (prob[j]) prob[j] = 0;
        mmu_beats = 1;

        // reset two cycles into port 1's transaction
        do_reset();
        mmu_lat = 10;
        step();
        req_in[1] = '{valid: 1'b1, write: 1'b1, addr: 32'h0000_4000, wdata: 32'hA5A5_0001};
        for (int i = 0; i < 20 && !grant_valid; i++) @(negedge clk);
        check("t5_granted_port1", 128'({grant_valid, 2'(grant_id)}), 128'({1'b1, 2'd1}));
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_async_grant_valid", 128'(grant_valid), 128'(0));
        check("t5_async_grant_id", 128'(grant_id), 128'(0));
        check("t5_async_req_out", 128'(req_out), 128'(0));
        for (int j = 0; j < N; j++) check($sformatf("t5_async_resp_out%0d", j), 128'(resp_out[j]), 128'(0));
        step();
        req_in[0] = '{valid: 1'b1, write: 1'b0, addr: 32'h0000_8000, wdata: 32'h0};
        step();
        grant_q.delete();
        rst = 1'b0;
        wait_grants("t5", 1, 50);
        check("t5_first_after_reset", 128'(grant_at(0)), 128'(0));

        // port 1 arrives in port 0's completion cycle
        do_reset();
        mmu_lat = 3;
        step();
        req_in[0] = '{valid: 1'b1, write: 1'b0, addr: 32'h1000_0000, wdata: 32'h0};
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_out[0].ready && resp_out[0].last) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_port0_done", 128'(found), 128'(1));
        #1 req_in[1] = '{valid: 1'b1, write: 1'b0, addr: 32'h2000_0000, wdata: 32'h0};
        @(negedge clk);
        check("t6_c1_req_valid", 128'(req_out.valid), 128'(0));
        check("t6_c1_grant_valid", 128'(grant_valid), 128'(0));
        @(negedge clk);
        check("t6_c2_grant_valid", 128'(grant_valid), 128'(0));
        @(negedge clk);
        check("t6_c3_grant", 128'({grant_valid, 2'(grant_id), req_out.valid}), 128'({1'b1, 2'd1, 1'b1}));

        // random traffic with random MMU timing
        do_reset();
        mmu_rand = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            for (int j = 0; j < N; j++) prob[j] = int'($urandom_range(90, 20));
            repeat (400) step();
        end
        foreach (prob[j]) prob[j] = 0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Round-robin arbiter that shares the single MMU/memory cbus port between N requesters, e.g. instruction fetch and data access. It sits between the core-side requesters and the `mmu` request input. It grants one requester at a time and forwards that requester's cbus request unchanged. It routes the response back to the granted port only. It holds the grant until the transaction completes (`ready && last`), then inserts one idle release cycle before arbitrating again.

## Interface
- `N`, default 2: number of requesters; legal range 2..8. Port 0 is fetch and port 1 is data by convention.
- `GW`, default `$clog2(N)`: width of the grant index. Derived; do not override.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_in[N]`  in  `cbus_req_t`  requests from the requesters.
- `resp_out[N]`  out  `cbus_resp_t`  responses to the requesters.
- `req_out`  out  `cbus_req_t`  request to the MMU.
- `resp_in`  in  `cbus_resp_t`  response from the MMU.
- `grant_valid`  out  1  a transaction is currently owned.
- `grant_id`  out  GW  index of the owning requester; 0 when `grant_valid`=0.

## Operation
- The state machine has three states: IDLE, BUSY and RELEASE. Encode them as `arb_state_t`.
- **IDLE**
  - If any `req_in[i].valid` is high, select the winner by round-robin.
  - The search starts at `(last_grant+1) mod N` and takes the first valid index in increasing order, wrapping around.
  - Register `grant_id`=winner, set `grant_valid`=1 and go to BUSY.
  - If no request is valid, stay in IDLE.
- **BUSY**
  - `req_out` = `req_in[grant_id]`, combinational pass-through of all fields. The MMU re-reads the address during its page walk, so the requester must hold the request stable.
  - `resp_out[grant_id]` = `resp_in`.
  - All other `resp_out[j]` have `ready`=0, `last`=0 and `data`=0.
  - On `resp_in.ready && resp_in.last`:
    - set `last_grant` = `grant_id`;
    - clear `grant_valid` and zero `grant_id`;
    - go to RELEASE.
  - Responses with `ready`=1 and `last`=0 are forwarded and BUSY continues.
- **RELEASE**
  - Lasts exactly one cycle; `req_out.valid`=0. This gives the finished requester time to drop `valid` and the MMU time to return to its idle state.
  - Then go to IDLE. No arbitration happens in RELEASE.
- **`req_out` outside BUSY:** all fields are 0 (`valid`=0).
- **Requester drops `valid` while BUSY:** this is a protocol violation. The arbiter does not abort. It stays in BUSY until `ready && last`. Simulation assertion: `req_in[grant_id].valid` must remain high in BUSY.
- **Non-granted requests:** they stay pending. No request is dropped or queued beyond its own `valid`.
- **Starvation bound:** a continuously valid requester is granted within N−1 intervening transactions.

## Timing
- **Reset values:**
  - state = IDLE;
  - `last_grant` = N−1, so port 0 has first priority;
  - `grant_valid`=0 and `grant_id`=0;
  - `req_out` is all zero;
  - every `resp_out` is all zero.
- **Reset mid-transaction:** on the reset edge all outputs return to their reset values immediately (asynchronous). The MMU is reset by the same `rst`.
- **Latency:**
  - A request is first seen valid in IDLE at cycle t. `req_out.valid` rises at t+1.
  - Response to requester: zero added latency, combinational from `resp_in`.
  - Completion seen at cycle c. RELEASE occupies c+1. The next grant decision is made at c+2, and the next `req_out.valid` rises at c+3.
- **Simultaneous requests in IDLE:** resolved only by the round-robin pointer, never by a fixed priority.
- **Completion in the same cycle another port raises `valid`:** the new request waits for RELEASE and IDLE as normal.
- **Minimum occupancy:** one transaction occupies at least three cycles from IDLE to IDLE.

## Structure
- Add `arb_state_t` (enum: IDLE, BUSY, RELEASE) to package `common`.
- `cbus_req_t` and `cbus_resp_t` are already in `common`; reuse them.
- One natural sub-module is `rr_pick`. It is combinational: inputs are an N-bit valid vector and the `last_grant` pointer; outputs are the winner index and an any-valid flag. Reuse it for future arbiters.
- The top holds the state register, `last_grant`, `grant_id` and the response/request muxes.

## Test plan
- **Single requester:** reset; `req_in[0]` valid with addr 0x8000_0000; the MMU model answers `ready`=`last`=1 with data 0x1234 five cycles later.
  - `req_out.valid` rises one cycle after the request.
  - `resp_out[0].data`=0x1234.
  - `resp_out[1]` stays zero.
  - RELEASE cycle follows with `req_out.valid`=0.
- **Simultaneous requests after reset:** ports 0 and 1 both held valid.
  - Grant order is 0, 1, 0, 1 over four transactions.
  - `grant_id` matches the owner on each transaction.
- **Three ports (N=3), all valid continuously:** the grant sequence is 0, 1, 2, 0. No port waits more than two transactions.
- **Burst-style response:** the model returns `ready`=1 with `last`=0 for three beats, then `last`=1.
  - The arbiter stays in BUSY through all beats.
  - All four beats reach the owner only.
  - The next grant happens only after RELEASE.
- **Reset mid-transaction:** assert `rst` two cycles into BUSY for port 1.
  - All outputs become zero immediately.
  - After reset, with both ports valid, port 0 is granted first.
- **Late arrival:** port 1 raises `valid` in the same cycle port 0 completes.
  - Port 1 is granted at completion+2.
  - `req_out.valid` is 0 during completion+1.
